// File: rtl/mul_inflight_tracker_if.sv
// ID-side issue signals and the Mk occupancy/stall outputs of the multiplier shadow pipeline.
// The pipeline control drives the master side and the tracker sits on the slave side.
interface mul_inflight_tracker_if;
  logic       id_valid;
  logic       id_is_mul;
  logic       id_writes_reg;
  logic [4:0] id_reg_dest_addr;
  logic [4:0] id_reg_a_addr;
  logic [4:0] id_reg_b_addr;
  logic       ext_stall_in;
  logic       flush_in;

  logic [4:0] m1_reg_dest_addr;
  logic [4:0] m2_reg_dest_addr;
  logic [4:0] m3_reg_dest_addr;
  logic [4:0] m4_reg_dest_addr;
  logic [4:0] m5_reg_dest_addr;
  logic       m1_is_mul;
  logic       m2_is_mul;
  logic       m3_is_mul;
  logic       m4_is_mul;
  logic       m5_is_mul;
  logic       wb_valid;
  logic [4:0] wb_reg_dest_addr;
  logic [2:0] inflight_count;
  logic       stall_out;

  modport master (
    output id_valid, id_is_mul, id_writes_reg,
    output id_reg_dest_addr, id_reg_a_addr, id_reg_b_addr,
    output ext_stall_in, flush_in,
    input  m1_reg_dest_addr, m2_reg_dest_addr, m3_reg_dest_addr,
    input  m4_reg_dest_addr, m5_reg_dest_addr,
    input  m1_is_mul, m2_is_mul, m3_is_mul, m4_is_mul, m5_is_mul,
    input  wb_valid, wb_reg_dest_addr, inflight_count, stall_out
  );

  modport slave (
    input  id_valid, id_is_mul, id_writes_reg,
    input  id_reg_dest_addr, id_reg_a_addr, id_reg_b_addr,
    input  ext_stall_in, flush_in,
    output m1_reg_dest_addr, m2_reg_dest_addr, m3_reg_dest_addr,
    output m4_reg_dest_addr, m5_reg_dest_addr,
    output m1_is_mul, m2_is_mul, m3_is_mul, m4_is_mul, m5_is_mul,
    output wb_valid, wb_reg_dest_addr, inflight_count, stall_out
  );
endinterface

// File: rtl/mul_inflight_tracker.sv
// Five-stage shadow of the fixed-latency multiplier: publishes Mk occupancy and raises
// stalls for RAW hazards on in-flight mul results and for RF write-port collisions.
module mul_inflight_tracker #(
  parameter int ALU_WB_DIST = 3,
  parameter bit WB_FORWARD  = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  mul_inflight_tracker_if.slave  bus
);
  localparam int DEPTH        = 5;
  localparam int RAW_DEPTH    = WB_FORWARD ? DEPTH - 1 : DEPTH;
  // Entry that retires in the same cycle a non-mul issued now would write back.
  localparam int CONFLICT_IDX = DEPTH - ALU_WB_DIST;

  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] valid_next;
  logic [4:0]       dest_reg  [DEPTH];
  logic [4:0]       dest_next [DEPTH];
  logic [2:0]       count_reg;
  logic [2:0]       count_next;
  logic [DEPTH-1:0] raw_match;
  logic             raw_hit;
  logic             conflict_hit;
  logic             stall;
  logic             issue;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_raw
      if (gi < RAW_DEPTH) begin : g_chk
        assign raw_match[gi] = valid_reg[gi] && (dest_reg[gi] != 5'd0) &&
                               ((dest_reg[gi] == bus.id_reg_a_addr) ||
                                (dest_reg[gi] == bus.id_reg_b_addr));
      end else begin : g_fwd
        assign raw_match[gi] = 1'b0;
      end
    end
  endgenerate

  assign raw_hit      = bus.id_valid & (|raw_match);
  assign conflict_hit = bus.id_valid & bus.id_writes_reg & ~bus.id_is_mul &
                        valid_reg[CONFLICT_IDX];
  assign stall        = (raw_hit | conflict_hit) & ~bus.flush_in;
  assign issue        = bus.id_valid & bus.id_is_mul & bus.id_writes_reg &
                        ~stall & ~bus.ext_stall_in & ~bus.flush_in;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_m1
        assign valid_next[gi] = issue;
        assign dest_next[gi]  = issue ? bus.id_reg_dest_addr : 5'd0;
      end else if (gi == 1) begin : g_m2
        // M1 is younger than the redirecting branch in EX, so it dies on flush.
        assign valid_next[gi] = valid_reg[gi-1] & ~bus.flush_in;
        assign dest_next[gi]  = bus.flush_in ? 5'd0 : dest_reg[gi-1];
      end else begin : g_mk
        assign valid_next[gi] = valid_reg[gi-1];
        assign dest_next[gi]  = dest_reg[gi-1];
      end
    end
  endgenerate

  always_comb begin
    count_next = 3'd0;
    for (int i = 0; i < DEPTH; i++) begin
      count_next = count_next + 3'(valid_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_reg <= '0;
      count_reg <= 3'd0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_reg[i] <= 5'd0;
      end
    end else begin
      valid_reg <= valid_next;
      count_reg <= count_next;
      for (int i = 0; i < DEPTH; i++) begin
        dest_reg[i] <= dest_next[i];
      end
    end
  end

  assign bus.m1_reg_dest_addr = dest_reg[0];
  assign bus.m2_reg_dest_addr = dest_reg[1];
  assign bus.m3_reg_dest_addr = dest_reg[2];
  assign bus.m4_reg_dest_addr = dest_reg[3];
  assign bus.m5_reg_dest_addr = dest_reg[4];
  assign bus.m1_is_mul        = valid_reg[0];
  assign bus.m2_is_mul        = valid_reg[1];
  assign bus.m3_is_mul        = valid_reg[2];
  assign bus.m4_is_mul        = valid_reg[3];
  assign bus.m5_is_mul        = valid_reg[4];
  assign bus.wb_valid         = valid_reg[4];
  assign bus.wb_reg_dest_addr = dest_reg[4];
  assign bus.inflight_count   = count_reg;
  assign bus.stall_out        = stall;
endmodule

// File: tb/tb_mul_inflight_tracker.sv
// Directed vectors for mul_inflight_tracker: the driver queues hand-computed expectations,
// and a negedge monitor pops and compares them against the DUT outputs.
module tb_mul_inflight_tracker;
  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   vec_idx;

  typedef struct {
    int         idx;
    logic       stall;
    logic [4:0] v;
    logic [2:0] cnt;
    logic [4:0] m1d;
    logic [4:0] wbd;
  } exp_t;

  exp_t exp_q[$];

  mul_inflight_tracker_if bus();

  mul_inflight_tracker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // Monitor: compare the oldest expectation against what the DUT shows this cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t       e;
      logic [4:0] act_v;
      e     = exp_q.pop_front();
      act_v = {bus.m5_is_mul, bus.m4_is_mul, bus.m3_is_mul, bus.m2_is_mul, bus.m1_is_mul};
      total++;
      if (bus.stall_out !== e.stall) begin
        bad++;
        $display("FAIL v%0d stall_out: got %b want %b", e.idx, bus.stall_out, e.stall);
      end
      total++;
      if (act_v !== e.v) begin
        bad++;
        $display("FAIL v%0d is_mul m5..m1: got %b want %b", e.idx, act_v, e.v);
      end
      total++;
      if (bus.wb_valid !== e.v[4]) begin
        bad++;
        $display("FAIL v%0d wb_valid: got %b want %b", e.idx, bus.wb_valid, e.v[4]);
      end
      total++;
      if (bus.inflight_count !== e.cnt) begin
        bad++;
        $display("FAIL v%0d inflight_count: got %0d want %0d", e.idx, bus.inflight_count, e.cnt);
      end
      total++;
      if (bus.m1_reg_dest_addr !== e.m1d) begin
        bad++;
        $display("FAIL v%0d m1_reg_dest_addr: got %0d want %0d", e.idx, bus.m1_reg_dest_addr, e.m1d);
      end
      if (e.v[4]) begin
        total++;
        if (bus.wb_reg_dest_addr !== e.wbd || bus.m5_reg_dest_addr !== e.wbd) begin
          bad++;
          $display("FAIL v%0d wb_reg_dest_addr: got %0d/%0d want %0d", e.idx,
                   bus.wb_reg_dest_addr, bus.m5_reg_dest_addr, e.wbd);
        end
      end
    end
  end

  task automatic vec(input logic rst_n, input logic v, input logic mul, input logic wr,
                     input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                     input logic ext, input logic fl,
                     input logic e_stall, input logic [4:0] e_v, input logic [2:0] e_cnt,
                     input logic [4:0] e_m1d, input logic [4:0] e_wbd);
    exp_t e;
    @(posedge clk);
    #1;
    vec_idx++;
    reset                = rst_n;
    bus.id_valid         = v;
    bus.id_is_mul        = mul;
    bus.id_writes_reg    = wr;
    bus.id_reg_dest_addr = d;
    bus.id_reg_a_addr    = a;
    bus.id_reg_b_addr    = b;
    bus.ext_stall_in     = ext;
    bus.flush_in         = fl;
    e.idx   = vec_idx;
    e.stall = e_stall;
    e.v     = e_v;
    e.cnt   = e_cnt;
    e.m1d   = e_m1d;
    e.wbd   = e_wbd;
    exp_q.push_back(e);
    $display("vec %0d: rst_n=%b v=%b mul=%b wr=%b d=%0d a=%0d b=%0d ext=%b fl=%b", vec_idx,
             rst_n, v, mul, wr, d, a, b, ext, fl);
  endtask

  task automatic idle(input logic e_stall, input logic [4:0] e_v, input logic [2:0] e_cnt,
                      input logic [4:0] e_m1d, input logic [4:0] e_wbd);
    vec(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, e_stall, e_v, e_cnt, e_m1d, e_wbd);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    vec_idx = 0;
    reset                = 1'b0;
    bus.id_valid         = 1'b1;
    bus.id_is_mul        = 1'b1;
    bus.id_writes_reg    = 1'b1;
    bus.id_reg_dest_addr = 5'd3;
    bus.id_reg_a_addr    = 5'd1;
    bus.id_reg_b_addr    = 5'd2;
    bus.ext_stall_in     = 1'b0;
    bus.flush_in         = 1'b0;

    // Reset held with a mul presented, then released: the mul issues afterwards.
    vec(0, 1, 1, 1, 3, 1, 2, 0, 0,   0, 5'b00000, 0, 0, 0);
    vec(0, 1, 1, 1, 3, 1, 2, 0, 0,   0, 5'b00000, 0, 0, 0);
    vec(1, 1, 1, 1, 3, 1, 2, 0, 0,   0, 5'b00000, 0, 0, 0);
    idle(0, 5'b00001, 1, 3, 0);
    // Propagation of mul x7 through M1..M5, overlapping the tail of x3.
    vec(1, 1, 1, 1, 7, 0, 0, 0, 0,   0, 5'b00010, 1, 0, 0);
    idle(0, 5'b00101, 2, 7, 0);
    idle(0, 5'b01010, 2, 0, 0);
    idle(0, 5'b10100, 2, 0, 3);
    idle(0, 5'b01000, 1, 0, 0);
    idle(0, 5'b10000, 1, 0, 7);
    // RAW: ADD reading x7 stalls for M1..M4 and goes once x7 is forwardable from M5.
    vec(1, 1, 1, 1, 7, 1, 2, 0, 0,   0, 5'b00000, 0, 0, 0);
    vec(1, 1, 0, 1, 10, 7, 1, 0, 0,  1, 5'b00001, 1, 7, 0);
    vec(1, 1, 0, 1, 10, 7, 1, 0, 0,  1, 5'b00010, 1, 0, 0);
    vec(1, 1, 0, 1, 10, 7, 1, 0, 0,  1, 5'b00100, 1, 0, 0);
    vec(1, 1, 0, 1, 10, 7, 1, 0, 0,  1, 5'b01000, 1, 0, 0);
    vec(1, 1, 0, 1, 10, 7, 1, 0, 0,  0, 5'b10000, 1, 0, 7);
    // Mul to x0 occupies a slot but never causes a RAW stall.
    vec(1, 1, 1, 1, 0, 0, 0, 0, 0,   0, 5'b00000, 0, 0, 0);
    vec(1, 1, 0, 0, 0, 0, 0, 0, 0,   0, 5'b00001, 1, 0, 0);
    vec(1, 1, 0, 0, 0, 0, 0, 0, 0,   0, 5'b00010, 1, 0, 0);
    vec(1, 1, 0, 0, 0, 0, 0, 0, 0,   0, 5'b00100, 1, 0, 0);
    vec(1, 1, 0, 0, 0, 0, 0, 0, 0,   0, 5'b01000, 1, 0, 0);
    vec(1, 1, 0, 0, 0, 0, 0, 0, 0,   0, 5'b10000, 1, 0, 0);
    // Write-port conflict: ALU writer stalls only while mul x5 sits in M3.
    vec(1, 1, 1, 1, 5, 0, 0, 0, 0,   0, 5'b00000, 0, 0, 0);
    idle(0, 5'b00001, 1, 5, 0);
    idle(0, 5'b00010, 1, 0, 0);
    vec(1, 1, 0, 1, 10, 1, 2, 0, 0,  1, 5'b00100, 1, 0, 0);
    vec(1, 1, 0, 1, 10, 1, 2, 0, 0,  0, 5'b01000, 1, 0, 0);
    vec(1, 1, 0, 0, 0, 1, 2, 0, 0,   0, 5'b10000, 1, 0, 5);
    // A store with M3 occupied does not stall.
    vec(1, 1, 1, 1, 5, 0, 0, 0, 0,   0, 5'b00000, 0, 0, 0);
    idle(0, 5'b00001, 1, 5, 0);
    idle(0, 5'b00010, 1, 0, 0);
    vec(1, 1, 0, 0, 0, 1, 2, 0, 0,   0, 5'b00100, 1, 0, 0);
    idle(0, 5'b01000, 1, 0, 0);
    idle(0, 5'b10000, 1, 0, 5);
    // Flush kills M1 on its way to M2 and blocks the mul in ID.
    vec(1, 1, 1, 1, 9, 0, 0, 0, 0,   0, 5'b00000, 0, 0, 0);
    vec(1, 1, 1, 1, 11, 0, 0, 0, 1,  0, 5'b00001, 1, 9, 0);
    // A flushed ID instruction with a RAW hazard does not stall.
    vec(1, 1, 1, 1, 12, 0, 0, 0, 0,  0, 5'b00000, 0, 0, 0);
    vec(1, 1, 0, 1, 10, 12, 0, 0, 1, 0, 5'b00001, 1, 12, 0);
    idle(0, 5'b00000, 0, 0, 0);
    // Back-to-back muls, bubble from ext_stall_in, fill to 5 with simultaneous retire.
    vec(1, 1, 1, 1, 1, 0, 0, 0, 0,   0, 5'b00000, 0, 0, 0);
    vec(1, 1, 1, 1, 2, 0, 0, 0, 0,   0, 5'b00001, 1, 1, 0);
    vec(1, 1, 1, 1, 3, 0, 0, 1, 0,   0, 5'b00011, 2, 2, 0);
    vec(1, 1, 1, 1, 3, 0, 0, 0, 0,   0, 5'b00110, 2, 0, 0);
    vec(1, 1, 1, 1, 4, 0, 0, 0, 0,   0, 5'b01101, 3, 3, 0);
    vec(1, 1, 1, 1, 5, 0, 0, 0, 0,   0, 5'b11011, 4, 4, 1);
    vec(1, 1, 1, 1, 6, 0, 0, 0, 0,   0, 5'b10111, 4, 5, 2);
    vec(1, 1, 1, 1, 8, 0, 0, 0, 0,   0, 5'b01111, 4, 6, 0);
    vec(1, 1, 1, 1, 9, 0, 0, 0, 0,   0, 5'b11111, 5, 8, 3);
    idle(0, 5'b11111, 5, 9, 4);
    idle(0, 5'b11110, 4, 0, 5);
    idle(0, 5'b11100, 3, 0, 6);
    idle(0, 5'b11000, 2, 0, 8);
    idle(0, 5'b10000, 1, 0, 9);
    // Reset mid-flight discards entries without retiring them.
    vec(1, 1, 1, 1, 13, 0, 0, 0, 0,  0, 5'b00000, 0, 0, 0);
    idle(0, 5'b00001, 1, 13, 0);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 5'b00010, 1, 0, 0);
    idle(0, 5'b00000, 0, 0, 0);
    // RAW stall together with ext_stall_in: no issue, pipeline drains.
    vec(1, 1, 1, 1, 14, 0, 0, 0, 0,  0, 5'b00000, 0, 0, 0);
    vec(1, 1, 1, 1, 15, 14, 0, 1, 0, 1, 5'b00001, 1, 14, 0);
    idle(0, 5'b00010, 1, 0, 0);

    repeat (3) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mul_inflight_tracker.md
Name: mul_inflight_tracker

Overview:
- Producer side of the multiplier-occupancy interface: a 5-entry shift pipeline shadowing the fixed-latency multiplier.
- Generates the m1..m5 reg_dest_addr / is_mul signals that the load-use stall logic consumes.
- Also raises its own stall for RAW hazards on in-flight mul results, and for register-file write-port conflicts between a retiring mul and a younger ALU op.
- Sits beside the ID/EX boundary. Its stall is ORed with the load-use stall by the pipeline control.

Parameters:
- ALU_WB_DIST, 3: cycles from ID until a non-mul instruction writes the RF. Legal range 1..4.
- WB_FORWARD, 1: 1 means the M5 result is forwardable, so M5 causes no RAW stall. 0 means M5 also stalls.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_is_mul  in  1  ID instruction is a multiply
- id_writes_reg  in  1  ID instruction writes the RF
- id_reg_dest_addr  in  5  ID destination register
- id_reg_a_addr  in  5  ID source A
- id_reg_b_addr  in  5  ID source B
- ext_stall_in  in  1  other stall sources (load-use, memory); ID held
- flush_in  in  1  branch redirect from EX
- m1_reg_dest_addr..m5_reg_dest_addr  out  5 each  destination of the entry in Mk
- m1_is_mul..m5_is_mul  out  1 each  Mk holds a valid mul
- wb_valid  out  1  a mul retires this cycle (equals m5_is_mul)
- wb_reg_dest_addr  out  5  retiring mul destination (equals m5_reg_dest_addr)
- inflight_count  out  3  number of valid entries, 0..5
- stall_out  out  1  combinational stall request

Behaviour:
- Reset (reset==0 at a clk edge):
  - All mk_is_mul=0 and mk_reg_dest_addr=0.
  - inflight_count=0.
  - stall_out=0 in the following cycle, since the entries are cleared and stall_out is combinational.
  - Reset mid-operation discards in-flight entries without retiring them; wb_valid=0 next cycle.
- Pipeline advance:
  - Unconditional every cycle; the multiplier never stalls.
  - Mk+1 <= Mk for k=1..4. M5 contents are dropped after one cycle in M5.
- Issue: issue = id_valid & id_is_mul & id_writes_reg & ~stall_out & ~ext_stall_in & ~flush_in.
  - M1 <= {issue, issue ? id_reg_dest_addr : 5'd0}.
  - A mul with dest x0 occupies a slot (is_mul=1, addr=0) but never matches for hazards.
- Flush: when flush_in=1, no issue occurs this cycle. The entry moving M1->M2 is invalidated, because it is younger than the branch in EX. M2..M5 entries advance untouched.
- RAW stall term:
  - Asserted when id_valid and some Mk has is_mul=1 and reg_dest_addr!=0 and reg_dest_addr equals id_reg_a_addr or id_reg_b_addr.
  - k ranges over 1..4 if WB_FORWARD=1, and 1..5 if WB_FORWARD=0.
- Write-port conflict term:
  - Asserted when id_valid & id_writes_reg & ~id_is_mul & M(5-ALU_WB_DIST+1) is_mul.
  - With the default ALU_WB_DIST=3 the checked entry is M3. That entry retires in the same cycle the ALU op would reach WB.
- stall_out = (RAW | conflict) & ~flush_in. A flushed ID instruction never stalls.
- Issue gating: the RAW check covers mul-after-mul. A stalled mul does not enter M1, and it re-evaluates every cycle.
- inflight_count: registered popcount of the next-state valid bits; always equals the popcount of m1..m5_is_mul.
- Simultaneous events:
  - Issue and M5 retire in the same cycle are both legal; the count is net.
  - ext_stall_in and stall_out together: no issue occurs, and the pipeline still drains.

Test Plan:
- Reset then idle:
  - Stimulus: hold reset=0 for 2 cycles with id_valid=1 and a mul presented, then release.
  - Required response: all mk_is_mul=0, inflight_count=0 and stall_out=0 during reset.
  - After release, the mul issues: m1_is_mul=1 on the next cycle.
- Mul issue/propagation:
  - Stimulus: issue a mul with dest x7 at cycle 0.
  - Required response: mk_is_mul=1 with addr=7 at cycle k, for k=1..5.
  - wb_valid=1 with wb_reg_dest_addr=7 at cycle 5, and inflight_count=0 at cycle 6.
- RAW stall:
  - Stimulus: issue mul x7, then present ADD with source a=x7.
  - Required response: stall_out=1 for exactly 4 cycles with WB_FORWARD=1, or 5 cycles with WB_FORWARD=0, then release.
  - With dest x0, stall_out is never asserted.
- Write-port conflict:
  - Stimulus: mul x5 in M3 and a non-mul writer in ID with unrelated sources.
  - Required response: stall_out=1 for exactly that cycle.
  - A non-writing ID instruction (store) gives stall_out=0.
- Flush:
  - Stimulus: issue mul x9, then flush_in=1 on the next cycle.
  - Required response: the M2 entry for x9 is invalid and inflight_count=0.
  - A mul in ID during the flush does not issue.
- Back-to-back:
  - Stimulus: 5 independent muls issued on consecutive cycles with ext_stall_in toggling on the third.
  - Required response: the bubble appears in M1 for the stalled cycle.
  - inflight_count tracks exactly and never exceeds 5.
